// File: rtl/mips_reg_dump_if.sv
// Bundle of every non-clock/reset signal of the register-file dump engine.
//   master : the dump engine (drives read addresses, output stream, status)
//   slave  : the environment (register file, consumer and controller)
// Signals:
//   start/abort             control pulses into the engine
//   read_reg_1/read_reg_2   register-file read addresses (even/odd of a pair)
//   read_data_1/read_data_2 combinational register-file read data
//   out_valid/out_ready     stream handshake, out_data/out_index the payload
//   busy/done/checksum      status and result of the dump
interface mips_reg_dump_if #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] read_reg_1;
  logic [ADDR_WIDTH-1:0] read_reg_2;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic [DATA_WIDTH-1:0] read_data_2;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_index;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] checksum;

  modport master (
    input  start, abort, read_data_1, read_data_2, out_ready,
    output read_reg_1, read_reg_2, out_valid, out_data, out_index, busy, done, checksum
  );

  modport slave (
    output start, abort, read_data_1, read_data_2, out_ready,
    input  read_reg_1, read_reg_2, out_valid, out_data, out_index, busy, done, checksum
  );
endinterface

// File: rtl/mips_reg_dump.sv
// Read-side dump engine for the MIPS register file. On start it reads the file two
// registers per pass through its two combinational read ports, buffers the pair and
// streams both words out over valid/ready, then pulses done with a wrapping checksum.
// Ports:
//   clk     system clock, all state changes on posedge
//   reset   asynchronous active-high reset
//   io_bus  mips_reg_dump_if.master (control, read port, output stream, status)
module mips_reg_dump #(
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  mips_reg_dump_if.master  io_bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StSendA,
    StSendB,
    StDone
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LastK = ADDR_WIDTH'(NUM_REGS / 2 - 1);

  state_e                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_k, w_k_next;
  logic [ADDR_WIDTH-1:0] r_addr_1, w_addr_1_next;
  logic [ADDR_WIDTH-1:0] r_addr_2, w_addr_2_next;
  logic [DATA_WIDTH-1:0] r_hold_a, w_hold_a_next;
  logic [DATA_WIDTH-1:0] r_hold_b, w_hold_b_next;
  logic [DATA_WIDTH-1:0] r_sum, w_sum_next;
  logic [DATA_WIDTH-1:0] r_checksum, w_checksum_next;
  logic                  w_hs;

  assign w_hs = io_bus.out_valid && io_bus.out_ready;

  always_comb begin
    w_state_next    = r_state;
    w_k_next        = r_k;
    w_sum_next      = r_sum;
    w_checksum_next = r_checksum;
    w_hold_a_next   = r_hold_a;
    w_hold_b_next   = r_hold_b;

    unique case (r_state)
      StIdle: begin
        if (io_bus.start && !io_bus.abort) begin
          w_state_next = StRead;
          w_k_next     = '0;
          w_sum_next   = '0;
        end
      end
      StRead: begin
        // Snapshot of the pair is taken at the edge closing this cycle.
        w_hold_a_next = io_bus.read_data_1;
        w_hold_b_next = io_bus.read_data_2;
        w_state_next  = StSendA;
      end
      StSendA: begin
        if (w_hs) begin
          w_sum_next   = r_sum + r_hold_a;
          w_state_next = StSendB;
        end
      end
      StSendB: begin
        if (w_hs) begin
          w_sum_next = r_sum + r_hold_b;
          if (r_k == LastK) begin
            w_checksum_next = r_sum + r_hold_b;
            w_state_next    = StDone;
          end else begin
            w_k_next     = r_k + ADDR_WIDTH'(1);
            w_state_next = StRead;
          end
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase

    // Abort beats any handshake; the partial sum is dropped, the last checksum kept.
    if (io_bus.abort && (r_state != StIdle)) begin
      w_state_next    = StIdle;
      w_k_next        = r_k;
      w_sum_next      = r_sum;
      w_checksum_next = r_checksum;
    end
  end

  // Addresses are registered so the read port sees a clean value for the whole
  // READ cycle; they stay on the current pair while its words are sent.
  always_comb begin
    w_addr_1_next = r_addr_1;
    w_addr_2_next = r_addr_2;
    if (w_state_next == StRead) begin
      w_addr_1_next = w_k_next << 1;
      w_addr_2_next = (w_k_next << 1) | ADDR_WIDTH'(1);
    end else if (w_state_next == StIdle) begin
      w_addr_1_next = '0;
      w_addr_2_next = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_k        <= '0;
      r_addr_1   <= '0;
      r_addr_2   <= '0;
      r_hold_a   <= '0;
      r_hold_b   <= '0;
      r_sum      <= '0;
      r_checksum <= '0;
    end else begin
      r_state    <= w_state_next;
      r_k        <= w_k_next;
      r_addr_1   <= w_addr_1_next;
      r_addr_2   <= w_addr_2_next;
      r_hold_a   <= w_hold_a_next;
      r_hold_b   <= w_hold_b_next;
      r_sum      <= w_sum_next;
      r_checksum <= w_checksum_next;
    end
  end

  always_comb begin
    io_bus.out_valid = 1'b0;
    io_bus.out_data  = '0;
    io_bus.out_index = '0;
    unique case (r_state)
      StSendA: begin
        io_bus.out_valid = 1'b1;
        io_bus.out_data  = r_hold_a;
        io_bus.out_index = r_addr_1;
      end
      StSendB: begin
        io_bus.out_valid = 1'b1;
        io_bus.out_data  = r_hold_b;
        io_bus.out_index = r_addr_2;
      end
      default: begin
        io_bus.out_valid = 1'b0;
      end
    endcase
  end

  assign io_bus.read_reg_1 = r_addr_1;
  assign io_bus.read_reg_2 = r_addr_2;
  assign io_bus.busy       = (r_state != StIdle);
  assign io_bus.done       = (r_state == StDone);
  assign io_bus.checksum   = r_checksum;

endmodule

// File: doc/mips_reg_dump.md
Name: mips_reg_dump

Overview:
- Read-side initiator for the 8 x 32 MIPS register file.
- On a start pulse it walks every register through the file's two combinational read ports, two registers per pass.
- It buffers each pair and streams the words out over a valid/ready interface to the debug/trace path, then reports a wrapping 32-bit checksum of the dump.
- It only reads; it never drives the file's write port.

Parameters:
- NUM_REGS, 8, number of registers dumped; must be even and >= 2.
- ADDR_WIDTH, 3, register address width; 2**ADDR_WIDTH >= NUM_REGS.
- DATA_WIDTH, 32, register word width.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump; honoured only in IDLE.
- abort  input  1  synchronous cancel; returns to IDLE, no done pulse.
- read_reg_1  output  ADDR_WIDTH  address to register-file read port 1 (even register of the pair).
- read_reg_2  output  ADDR_WIDTH  address to register-file read port 2 (odd register of the pair).
- read_data_1  input  DATA_WIDTH  combinational data from read port 1.
- read_data_2  input  DATA_WIDTH  combinational data from read port 2.
- out_valid  output  1  out_data/out_index hold a valid word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready at posedge.
- out_data  output  DATA_WIDTH  register contents being emitted.
- out_index  output  ADDR_WIDTH  register number of out_data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last word is accepted.
- checksum  output  DATA_WIDTH  mod-2**DATA_WIDTH sum of all emitted words; valid from the done pulse until the next accepted start.

Behaviour:
- Reset (async, any state): state=IDLE, pair pointer k=0, read_reg_1=0, read_reg_2=0, out_valid=0, out_data=0, out_index=0, busy=0, done=0, checksum=0, hold registers=0.
- States:
  - IDLE: addresses held at 0. On start: k=0, running sum=0, go to READ.
  - READ: read_reg_1=2k, read_reg_2=2k+1, driven from registers for the whole cycle. At the closing posedge capture read_data_1 into hold_a and read_data_2 into hold_b, then go to SEND_A.
  - SEND_A: out_valid=1, out_data=hold_a, out_index=2k. On handshake: sum += hold_a, go to SEND_B.
  - SEND_B: out_valid=1, out_data=hold_b, out_index=2k+1. On handshake: sum += hold_b. If k==NUM_REGS/2-1, go to DONE; else k++ and go to READ.
  - DONE: done=1 for exactly this cycle, checksum=final sum, busy=1. Next state is IDLE unconditionally.
- out_data and out_index are stable while out_valid=1 and out_ready=0; the block must not withdraw out_valid without a handshake, except on abort or reset.
- Latency with out_ready tied high: start accepted at cycle 0; READ occupies 1 cycle per pair and each word takes 1 cycle, so 3 cycles per pair. For NUM_REGS=8: 12 cycles from IDLE exit to DONE, done is asserted in cycle 13, and IDLE resumes in cycle 14.
- Snapshot: each pair is sampled in its own READ cycle. A register-file write landing after that sample is not reflected in the current dump; a write before that pair's READ is.
- start while busy: ignored, with no effect on state, k, or sum.
- abort (any non-IDLE state, including DONE): next state IDLE. out_valid, done, and busy drop next cycle. checksum keeps its previous completed value; the partial sum is discarded. abort has priority over handshake in the same cycle. abort together with start in IDLE: abort wins, stay IDLE.
- Checksum is wrapping addition; carry out of bit DATA_WIDTH-1 is dropped.
- Register 0 is dumped like any other register; its hardwired-zero behaviour is owned by the register file.

Test Plan:
- Reset mid-dump: assert reset during SEND_B of pair 2 -> all outputs return to reset values immediately (asynchronous); next start dumps from register 0.
- Full dump, out_ready=1: regs 0..7 = 0,1,2,...,7 -> words 0..7 with out_index 0..7 in order; done in cycle 13 after start; checksum=28; busy low in cycle 14.
- Backpressure: out_ready low for 5 cycles during SEND_A of pair 1 (reg 2 = 0xDEADBEEF) -> out_valid, out_data=0xDEADBEEF, and out_index=2 held steady; dump resumes in order; no word is dropped or duplicated.
- Checksum wrap: all regs 0xFFFFFFFF -> checksum=0xFFFFFFF8.
- Abort and stray start: pulse start during READ of pair 1 -> ignored. Pulse abort in SEND_B of pair 1 -> IDLE next cycle, no done pulse, checksum unchanged from the prior dump.
- Snapshot boundary: write 0x12345678 to reg 6 while pair 1 is being sent -> the dump shows 0x12345678 at index 6. Write reg 1 during SEND_B of pair 0 -> the dump shows the old value of reg 1.
